// File: rtl/split_hold_ctl.sv
// rtl/split_hold_ctl.sv - stopwatch split/lap-hold controller (LIVE/HOLD display select, lap counter)
// Macro SPLIT_HOLD_TIMEOUT_EN: hold auto-expires after HOLD_TICKS ticks; undefined = split toggles HOLD.
module split_hold_ctl #(
   parameter int HOLD_TICKS = 300
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       init_regs,
   input  logic       count_enabled,
   input  logic       split,
   input  logic       tick,
   output logic       load_lap,
   output logic       show_lap,
   output logic [3:0] lap_count,
   output logic       lap_full
);

   typedef enum logic {
      S_LIVE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_load_lap;
   logic [3:0] r_lap_count;
   logic       r_lap_full;
   logic       w_load_nxt;
   logic [3:0] w_count_nxt;
   logic       w_accept;
   logic [3:0] w_count_inc;

   // Splits while paused belong to the stopwatch controller, not to us.
   assign w_accept    = split & count_enabled & ~init_regs;
   assign w_count_inc = (r_lap_count == 4'd15) ? r_lap_count : r_lap_count + 4'd1;

`ifdef SPLIT_HOLD_TIMEOUT_EN
   localparam int TW = $clog2(HOLD_TICKS + 1);
   localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_TICKS);

   logic [TW-1:0] r_timer;
   logic [TW-1:0] w_timer_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timer <= '0;
      end else begin
         r_timer <= w_timer_nxt;
      end
   end
`else
   logic w_unused;
   assign w_unused = tick ^ (HOLD_TICKS == 0);
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_load_nxt  = 1'b0;
      w_count_nxt = r_lap_count;
`ifdef SPLIT_HOLD_TIMEOUT_EN
      w_timer_nxt = r_timer;
`endif
      if (init_regs) begin
         w_state_nxt = S_LIVE;
         w_count_nxt = 4'd0;
`ifdef SPLIT_HOLD_TIMEOUT_EN
         w_timer_nxt = '0;
`endif
      end else begin
         case (r_state)
            S_LIVE: begin
               if (w_accept) begin
                  w_state_nxt = S_HOLD;
                  w_load_nxt  = 1'b1;
                  w_count_nxt = w_count_inc;
`ifdef SPLIT_HOLD_TIMEOUT_EN
                  w_timer_nxt = HOLD_LOAD;
`endif
               end
            end
            S_HOLD: begin
`ifdef SPLIT_HOLD_TIMEOUT_EN
               // A new split beats an expiring tick in the same cycle.
               if (w_accept) begin
                  w_load_nxt  = 1'b1;
                  w_count_nxt = w_count_inc;
                  w_timer_nxt = HOLD_LOAD;
               end else if (tick) begin
                  if (r_timer <= TW'(1)) begin
                     w_state_nxt = S_LIVE;
                     w_timer_nxt = '0;
                  end else begin
                     w_timer_nxt = r_timer - TW'(1);
                  end
               end
`else
               if (w_accept) begin
                  w_state_nxt = S_LIVE;
               end
`endif
            end
            default: w_state_nxt = S_LIVE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_LIVE;
         r_load_lap  <= 1'b0;
         r_lap_count <= 4'd0;
         r_lap_full  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_load_lap  <= w_load_nxt;
         r_lap_count <= w_count_nxt;
         r_lap_full  <= (w_count_nxt == 4'd15);
      end
   end

   assign load_lap  = r_load_lap;
   assign show_lap  = (r_state == S_HOLD);
   assign lap_count = r_lap_count;
   assign lap_full  = r_lap_full;

endmodule

// File: tb/tb_split_hold_ctl.sv
// tb/tb_split_hold_ctl.sv - self-checking bench for split_hold_ctl (HOLD_TICKS=4, both macro builds)
module tb_split_hold_ctl;

   logic       clk = 1'b0;
   logic       reset;
   logic       init_regs;
   logic       count_enabled;
   logic       split;
   logic       tick;
   logic       load_lap;
   logic       show_lap;
   logic [3:0] lap_count;
   logic       lap_full;

   int checks   = 0;
   int failures = 0;
   int strobes  = 0;

   typedef struct {
      string      name;
      logic       init;
      logic       ce;
      logic       sp;
      logic       tk;
      logic       e_load;
      logic       e_show;
      logic [3:0] e_cnt;
      logic       e_full;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];

   split_hold_ctl #(.HOLD_TICKS(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .init_regs    (init_regs),
      .count_enabled(count_enabled),
      .split        (split),
      .tick         (tick),
      .load_lap     (load_lap),
      .show_lap     (show_lap),
      .lap_count    (lap_count),
      .lap_full     (lap_full)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(string n, logic i, logic c, logic s, logic t,
                               logic el, logic es, logic [3:0] ec);
      vec_t v;
      v.name   = n;
      v.init   = i;
      v.ce     = c;
      v.sp     = s;
      v.tk     = t;
      v.e_load = el;
      v.e_show = es;
      v.e_cnt  = ec;
      v.e_full = (ec == 4'd15);
      return v;
   endfunction

   task automatic add(string n, logic i, logic c, logic s, logic t,
                      logic el, logic es, logic [3:0] ec);
      vecs.push_back(mk(n, i, c, s, t, el, es, ec));
   endtask

   task automatic compare(string n, logic el, logic es, logic [3:0] ec, logic ef);
      checks++;
      if (load_lap !== el || show_lap !== es || lap_count !== ec || lap_full !== ef) begin
         failures++;
         $display("FAIL %s: got load=%0b show=%0b cnt=%0d full=%0b, want load=%0b show=%0b cnt=%0d full=%0b",
                  n, load_lap, show_lap, lap_count, lap_full, el, es, ec, ef);
      end
   endtask

   task automatic step(input vec_t v);
      vec_t e;
      init_regs     = v.init;
      count_enabled = v.ce;
      split         = v.sp;
      tick          = v.tk;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty", v.name);
      end else begin
         e = exp_q.pop_front();
         compare(e.name, e.e_load, e.e_show, e.e_cnt, e.e_full);
      end
      if (load_lap) strobes++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      logic [3:0] ec;

`ifdef SPLIT_HOLD_TIMEOUT_EN
      add("paused_split",  0, 0, 1, 0, 0, 0, 0);
      add("idle",          0, 1, 0, 0, 0, 0, 0);
      add("split",         0, 1, 1, 0, 1, 1, 1);
      add("tick1",         0, 1, 0, 1, 0, 1, 1);
      add("tick2",         0, 1, 0, 1, 0, 1, 1);
      add("tick3",         0, 1, 0, 1, 0, 1, 1);
      add("tick4_expire",  0, 1, 0, 1, 0, 0, 1);
      add("init",          1, 1, 0, 0, 0, 0, 0);
      add("split_b",       0, 1, 1, 0, 1, 1, 1);
      add("tick_b1",       0, 1, 0, 1, 0, 1, 1);
      add("tick_b2",       0, 1, 0, 1, 0, 1, 1);
      add("tick_b3",       0, 1, 0, 1, 0, 1, 1);
      add("split_and_tick",0, 1, 1, 1, 1, 1, 2);
      add("reload_t1",     0, 1, 0, 1, 0, 1, 2);
      add("reload_t2",     0, 1, 0, 1, 0, 1, 2);
      add("reload_t3",     0, 1, 0, 1, 0, 1, 2);
      add("reload_expire", 0, 1, 0, 1, 0, 0, 2);
      add("split_c",       0, 1, 1, 0, 1, 1, 3);
      add("tick_c1",       0, 1, 0, 1, 0, 1, 3);
      add("hold_paused_sp",0, 0, 1, 0, 0, 1, 3);
      add("hold_paused_tk",0, 0, 0, 1, 0, 1, 3);
      add("paused_sp_tk",  0, 0, 1, 1, 0, 1, 3);
      add("paused_expire", 0, 0, 0, 1, 0, 0, 3);
      add("init_over_all", 1, 1, 1, 1, 0, 0, 0);
      add("split_d",       0, 1, 1, 0, 1, 1, 1);
      add("init_in_hold",  1, 1, 1, 0, 0, 0, 0);
`else
      add("paused_split",  0, 0, 1, 0, 0, 0, 0);
      add("idle",          0, 1, 0, 0, 0, 0, 0);
      add("split",         0, 1, 1, 0, 1, 1, 1);
      for (int i = 0; i < 10; i++) add("tick_ignored", 0, 1, 0, 1, 0, 1, 1);
      add("split_toggle",  0, 1, 1, 0, 0, 0, 1);
      add("split_again",   0, 1, 1, 0, 1, 1, 2);
      add("hold_paused_sp",0, 0, 1, 0, 0, 1, 2);
      add("init_over_split",1,1, 1, 0, 0, 0, 0);
      add("split_d",       0, 1, 1, 0, 1, 1, 1);
      add("init_in_hold",  1, 1, 0, 0, 0, 0, 0);
`endif

      reset         = 1'b0;
      init_regs     = 1'b0;
      count_enabled = 1'b0;
      split         = 1'b0;
      tick          = 1'b0;
      #1 reset = 1'b1;
      #2;
      compare("reset_state", 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) step(vecs[i]);

      // Saturation: 17 accepted splits, counter pins at 15.
      strobes = 0;
      for (int k = 1; k <= 17; k++) begin
         ec = (k >= 15) ? 4'd15 : 4'(k);
         step(mk("sat_split", 0, 1, 1, 0, 1, 1, ec));
`ifndef SPLIT_HOLD_TIMEOUT_EN
         step(mk("sat_toggle", 0, 1, 1, 0, 0, 0, ec));
`endif
      end
      checks++;
      if (strobes != 17) begin
         failures++;
         $display("FAIL sat_strobes: got %0d strobes, want 17", strobes);
      end
      step(mk("sat_clear", 1, 0, 0, 0, 0, 0, 0));

      // Asynchronous reset between clock edges while holding.
      step(mk("pre_reset_split", 0, 1, 1, 0, 1, 1, 1));
      step(mk("pre_reset_hold",  0, 1, 0, 0, 0, 1, 1));
      #2 reset = 1'b1;
      #1;
      compare("async_reset", 0, 0, 0, 0);
      #2 reset = 1'b0;
      step(mk("post_reset_split", 0, 1, 1, 0, 1, 1, 1));
      step(mk("final_init",       1, 0, 0, 0, 0, 0, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/split_hold_ctl.md
SPLIT_HOLD_CTL -- requirements
Module: split_hold_ctl

Interface
REQ-001 Parameter HOLD_TICKS, default 300, number of tick pulses the lap display is held (3 s at 10 ms tick); legal range 1..511.
REQ-002 clk  input  1  system clock; the block has one clock domain.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 init_regs  input  1  stopwatch controller idle indication; high = datapath being cleared.
REQ-005 count_enabled  input  1  stopwatch controller counting indication.
REQ-006 split  input  1  single-cycle debounced split button pulse.
REQ-007 tick  input  1  single-cycle 10 ms time-base pulse.
REQ-008 load_lap  output  1  single-cycle strobe; lap register captures the running time.
REQ-009 show_lap  output  1  display mux select; 1 = lap register, 0 = live counter.
REQ-010 lap_count  output  4  number of laps captured since the last clear.
REQ-011 lap_full  output  1  high while lap_count = 15.

Function
REQ-012 Two-state FSM: LIVE (show_lap=0), HOLD (show_lap=1); all outputs registered.
REQ-013 LIVE, split=1, count_enabled=1, init_regs=0 -> HOLD next edge; load_lap=1 for exactly that one cycle; hold timer loaded with HOLD_TICKS; lap_count incremented.
REQ-014 LIVE, split=1, count_enabled=0 -> ignored (no strobe, no count change); split while paused belongs to the stopwatch controller.
REQ-015 HOLD, split=1, count_enabled=1 -> stay HOLD, load_lap pulse, timer reloaded to HOLD_TICKS, lap_count incremented.
REQ-016 HOLD, split=1, count_enabled=0 -> ignored; timer keeps running.
REQ-017 HOLD, tick=1 -> timer decrements by 1; when timer is 1 and tick=1 -> LIVE next edge, timer 0.
REQ-018 Split (accepted) and timer-expiring tick in the same cycle -> split wins: stay HOLD, timer reloaded.
REQ-019 count_enabled falling while in HOLD -> no state change; hold continues until expiry.
REQ-020 init_regs=1 in any state -> next edge LIVE, timer 0, lap_count 0, load_lap 0; overrides split and tick in the same cycle.
REQ-021 lap_count saturates at 15: further accepted splits still strobe load_lap and reload the timer but leave lap_count at 15.
REQ-022 lap_full combinational-free: registered, equal to (lap_count == 15).
REQ-023 Timer width = ceil(log2(HOLD_TICKS+1)) bits; no wrap below 0.
REQ-024 Latency: split sampled at edge N -> load_lap and show_lap valid after edge N.

Reset
REQ-025 reset=1 asynchronously forces: LIVE, show_lap=0, load_lap=0, lap_count=0, lap_full=0, timer=0.
REQ-026 Reset asserted mid-HOLD aborts the hold immediately; first edge after release evaluates inputs normally.

Configuration
REQ-027 Macro SPLIT_HOLD_TIMEOUT_EN defined: hold timer present; behaviour per REQ-017/018.
REQ-028 SPLIT_HOLD_TIMEOUT_EN undefined: no timer, tick ignored; in HOLD an accepted split returns to LIVE without load_lap and without lap_count change (toggle); HOLD also exits on init_regs.

Verification (HOLD_TICKS=4, SPLIT_HOLD_TIMEOUT_EN defined unless stated)
REQ-029 Reset, then count_enabled=1, one split pulse -> one-cycle load_lap, show_lap=1, lap_count=1; after 4 tick pulses show_lap=0.
REQ-030 count_enabled=0, init_regs=0, split pulse -> load_lap never asserts, show_lap=0, lap_count=0.
REQ-031 In HOLD after 3 ticks, split and tick in the same cycle -> show_lap stays 1, lap_count=2, 4 further ticks needed to return LIVE.
REQ-032 17 accepted splits -> 17 load_lap strobes, lap_count=15, lap_full=1; init_regs pulse -> lap_count=0, lap_full=0, show_lap=0.
REQ-033 reset asserted mid-HOLD between clock edges -> show_lap=0 and lap_count=0 without waiting for a clock edge.
REQ-034 SPLIT_HOLD_TIMEOUT_EN undefined: split -> HOLD, lap_count=1; 10 ticks -> still HOLD; second split -> LIVE, no load_lap, lap_count=1.
